// File: rtl/npc_mc_if.sv
// Shared valid/ready memory bus of npc_mc: one request channel and one response channel,
// carrying both instruction fetches and data accesses.
interface npc_mc_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/npc_mc.sv
// Multi-cycle RV32I/RV32E core on a single shared valid/ready memory bus.
// Optional NPC_MISALIGN_TRAP_EN: misaligned lh/lhu/sh/lw/sw halt with code 2 instead of being aligned down.
module npc_mc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned NR_REGS  = 32
) (
  input  logic            clk,
  input  logic            reset,
  npc_mc_if.master        mem,
  output logic [31:0]     pc,
  output logic            commit_valid,
  output logic [31:0]     commit_pc,
  output logic            halt,
  output logic [1:0]      halt_code,
  output logic [31:0]     halt_a0
);
  localparam int unsigned RW = $clog2(NR_REGS);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13,
                         OP_REG = 7'h33, OP_FENCE = 7'h0f;

  typedef enum logic [2:0] {S_IF_REQ, S_IF_WAIT, S_EX, S_MEM_REQ, S_MEM_WAIT, S_HALT} state_t;

  state_t      state;
  logic [31:0] instr;
  logic [31:0] regs [NR_REGS];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_v  = (32'(rs1) < NR_REGS) ? regs[rs1[RW-1:0]] : '0;
  assign rs2_v  = (32'(rs2) < NR_REGS) ? regs[rs2[RW-1:0]] : '0;

  // ALU shared by OP and OP-IMM; alt selects sub/sra
  logic [31:0] alu_b, alu_res;
  logic        alu_alt;
  always_comb begin
    alu_b   = (opcode == OP_REG) ? rs2_v : imm_i;
    alu_alt = instr[30] && ((opcode == OP_REG) ? (f3 == 3'd0 || f3 == 3'd5) : (f3 == 3'd5));
    unique case (f3)
      3'd0:    alu_res = alu_alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1:    alu_res = rs1_v << alu_b[4:0];
      3'd2:    alu_res = 32'($signed(rs1_v) < $signed(alu_b));
      3'd3:    alu_res = 32'(rs1_v < alu_b);
      3'd4:    alu_res = rs1_v ^ alu_b;
      3'd5:    alu_res = alu_alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6:    alu_res = rs1_v | alu_b;
      default: alu_res = rs1_v & alu_b;
    endcase
  end

  logic        legal, is_ebreak, is_load, is_store, wr_rd, use_rs1, use_rs2, taken, bad_reg, illegal;
  logic [31:0] rd_val, next_pc;
  always_comb begin
    legal = 1'b0; is_ebreak = 1'b0; is_load = 1'b0; is_store = 1'b0;
    wr_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    rd_val = '0; next_pc = pc + 32'd4;
    unique case (f3)
      3'd0:    taken = rs1_v == rs2_v;
      3'd1:    taken = rs1_v != rs2_v;
      3'd4:    taken = $signed(rs1_v) < $signed(rs2_v);
      3'd5:    taken = $signed(rs1_v) >= $signed(rs2_v);
      3'd6:    taken = rs1_v < rs2_v;
      default: taken = rs1_v >= rs2_v;
    endcase
    case (opcode)
      OP_LUI:   begin legal = 1'b1; wr_rd = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin legal = 1'b1; wr_rd = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:   begin legal = 1'b1; wr_rd = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
      OP_JALR: begin
        legal = (f3 == 3'd0); wr_rd = 1'b1; use_rs1 = 1'b1;
        rd_val = pc + 32'd4; next_pc = (rs1_v + imm_i) & ~32'd1;
      end
      OP_BR: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (taken) next_pc = pc + imm_b;
      end
      OP_LD: begin
        legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        is_load = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_ST:    begin legal = (f3 < 3'd3); is_store = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM: begin
        legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20);
        wr_rd = 1'b1; use_rs1 = 1'b1; rd_val = alu_res;
      end
      OP_REG: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; rd_val = alu_res;
      end
      OP_FENCE: legal = 1'b1;
      default:  is_ebreak = (instr == 32'h0010_0073);
    endcase
    bad_reg = (wr_rd && 32'(rd) >= NR_REGS) || (use_rs1 && 32'(rs1) >= NR_REGS) ||
              (use_rs2 && 32'(rs2) >= NR_REGS);
    illegal = !legal || bad_reg;
  end

  // Data access address, alignment and store lane formatting
  logic [31:0] raw_addr, acc_addr, st_wdata;
  logic [3:0]  st_mask;
  logic        misaligned, mis_trap;
  always_comb begin
    raw_addr   = rs1_v + (is_store ? imm_s : imm_i);
    misaligned = (f3[1:0] == 2'b01 && raw_addr[0]) || (f3[1:0] == 2'b10 && raw_addr[1:0] != 2'b00);
    acc_addr   = raw_addr;
    st_wdata   = rs2_v;
    st_mask    = 4'hF;
    if (f3[1:0] == 2'b00) begin
      st_wdata = {4{rs2_v[7:0]}};
      st_mask  = 4'b0001 << raw_addr[1:0];
    end else if (f3[1:0] == 2'b01) begin
      acc_addr[0] = 1'b0;
      st_wdata    = {2{rs2_v[15:0]}};
      st_mask     = raw_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      acc_addr[1:0] = 2'b00;
    end
  end

`ifdef NPC_MISALIGN_TRAP_EN
  assign mis_trap = (is_load || is_store) && misaligned;
`else
  assign mis_trap = 1'b0;
`endif

  // Load lane extraction from the aligned response word
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  always_comb begin
    unique case (mem.mem_req_addr[1:0])
      2'd0:    ld_byte = mem.mem_rsp_rdata[7:0];
      2'd1:    ld_byte = mem.mem_rsp_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rsp_rdata[23:16];
      default: ld_byte = mem.mem_rsp_rdata[31:24];
    endcase
    ld_half = mem.mem_req_addr[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
    unique case (f3)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {24'b0, ld_byte};
      3'd5:    ld_val = {16'b0, ld_half};
      default: ld_val = mem.mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IF_REQ;
      pc                <= RESET_PC;
      instr             <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wen   <= 1'b0;
      mem.mem_req_wdata <= '0;
      mem.mem_req_wmask <= '0;
      commit_valid      <= 1'b0;
      commit_pc         <= '0;
      halt              <= 1'b0;
      halt_code         <= '0;
      halt_a0           <= '0;
      for (int i = 0; i < int'(NR_REGS); i++) regs[i] <= '0;
    end else begin
      commit_valid <= 1'b0;
      case (state)
        S_IF_REQ: begin
          if (!mem.mem_req_valid) begin
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_addr  <= pc;
            mem.mem_req_wen   <= 1'b0;
            mem.mem_req_wdata <= '0;
            mem.mem_req_wmask <= '0;
          end else if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= S_IF_WAIT;
          end
        end
        S_IF_WAIT: if (mem.mem_rsp_valid) begin
          instr <= mem.mem_rsp_rdata;
          state <= S_EX;
        end
        S_EX: begin
          if (is_ebreak || illegal || mis_trap) begin
            halt      <= 1'b1;
            halt_code <= is_ebreak ? 2'd0 : (illegal ? 2'd1 : 2'd2);
            halt_a0   <= regs[RW'(10)];
            state     <= S_HALT;
          end else if (is_load || is_store) begin
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_addr  <= acc_addr;
            mem.mem_req_wen   <= is_store;
            mem.mem_req_wdata <= is_store ? st_wdata : '0;
            mem.mem_req_wmask <= is_store ? st_mask : '0;
            state             <= S_MEM_REQ;
          end else begin
            if (wr_rd && rd != 5'd0) regs[rd[RW-1:0]] <= rd_val;
            commit_valid      <= 1'b1;
            commit_pc         <= pc;
            pc                <= next_pc;
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_addr  <= next_pc;
            mem.mem_req_wen   <= 1'b0;
            mem.mem_req_wdata <= '0;
            mem.mem_req_wmask <= '0;
            state             <= S_IF_REQ;
          end
        end
        S_MEM_REQ: if (mem.mem_req_ready) begin
          mem.mem_req_valid <= 1'b0;
          state             <= S_MEM_WAIT;
        end
        S_MEM_WAIT: if (mem.mem_rsp_valid) begin
          if (is_load && rd != 5'd0) regs[rd[RW-1:0]] <= ld_val;
          commit_valid      <= 1'b1;
          commit_pc         <= pc;
          pc                <= pc + 32'd4;
          mem.mem_req_valid <= 1'b1;
          mem.mem_req_addr  <= pc + 32'd4;
          mem.mem_req_wen   <= 1'b0;
          mem.mem_req_wdata <= '0;
          mem.mem_req_wmask <= '0;
          state             <= S_IF_REQ;
        end
        default: ;
      endcase
    end
  end
endmodule
